mov_arbiter_ctrl: RTL and testbench
===================================

Name: mov_arbiter_ctrl

Overview:
- Controller that shares one register-to-register move datapath (N-bit copy path, read port to write port) between two requesters.
- Accepts move commands (src, dst register indices) over valid/ready handshakes and arbitrates round-robin.
- Sequences each move as a register-file read, then a write. Signals completion to the owning requester.
- Sits between the instruction/control logic and the register file ports.

Parameters:
- N, 32, datapath word width
- A, 5, register index width (2^A registers)
- CW, 16, completed-move counter width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- req0_valid  in  1  requester 0 has a move command
- req0_src  in  A  requester 0 source register index
- req0_dst  in  A  requester 0 destination register index
- req0_ready  out  1  requester 0 command accepted this cycle
- req1_valid  in  1  requester 1 has a move command
- req1_src  in  A  requester 1 source register index
- req1_dst  in  A  requester 1 destination register index
- req1_ready  out  1  requester 1 command accepted this cycle
- rf_raddr  out  A  register-file read address
- rf_rdata  in  N  register-file read data (combinational read)
- rf_we  out  1  register-file write enable
- rf_waddr  out  A  register-file write address
- rf_wdata  out  N  register-file write data
- done  out  2  one-cycle completion pulse, bit i = requester i
- busy  out  1  high when state is not IDLE
- move_count  out  CW  number of completed moves, wraps

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, last=1 (so requester 0 has priority first), src_q/dst_q/data_q/owner=0, done=0, move_count=0.
- Reset values of outputs: all ready=0, rf_we=0, rf_raddr=0, rf_waddr=0, rf_wdata=0, busy=0.
- States:
  - IDLE
  - READ
  - WRITE
- IDLE:
  - Grant goes to the requester with valid high.
  - If both are valid, grant goes to the requester other than last.
  - The granted requester's ready is high combinationally in IDLE only; the other ready stays 0.
  - On the accepting edge: latch src/dst, set owner=granted, last=granted, go to READ.
  - No valid: stay in IDLE.
- READ:
  - rf_raddr=src_q.
  - data_q <= rf_rdata at the clock edge; go to WRITE.
- WRITE:
  - rf_we=1, rf_waddr=dst_q, rf_wdata=data_q.
  - At the clock edge: done[owner] <= 1, move_count <= move_count+1 (mod 2^CW), go to IDLE.
- done is registered and is high exactly one cycle, the cycle after WRITE, which coincides with IDLE.
- done is 0 in all other cycles.
- Outside READ: rf_raddr=0. Outside WRITE: rf_we=0, rf_waddr=0, rf_wdata=0.
- Latency and throughput:
  - Acceptance edge to write cycle: 2 cycles. Acceptance edge to done: 3 cycles.
  - Maximum throughput is one move per 3 cycles.
  - A new command can be accepted in the same IDLE cycle in which done is high.
- src==dst: performs the full read and write unchanged, and counts as a move.
- valid is sampled only in IDLE. Requesters hold valid and command stable until ready. Commands changing while not ready are ignored.
- A valid dropped before ready produces no move.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1...
- Reset asserted mid-operation (READ or WRITE):
  - Immediate return to reset values.
  - No write is issued after assertion, no done pulse, count stays cleared.
- move_count wraps from 2^CW-1 to 0 with no flag.

Test Plan:
- Reset, then req0_valid=1, src=3, dst=7, RF[3]=0xDEADBEEF:
  - req0_ready=1 in the first IDLE cycle.
  - rf_raddr=3 in the next cycle.
  - Following cycle: rf_we=1, rf_waddr=7, rf_wdata=0xDEADBEEF.
  - Then done=2'b01, move_count=1.
- Both valid continuously, req0 (1→2), req1 (4→5), 4 moves:
  - Grant order 0,1,0,1.
  - done pulses alternate 01,10,01,10, one every 3 cycles.
  - move_count=4.
- req1 only, src=dst=9, RF[9]=0x12345678:
  - Write to 9 with 0x12345678.
  - done=2'b10; req0_ready stays 0 throughout.
- Assert rst during WRITE of move 6→8:
  - rf_we drops immediately and no done pulse occurs.
  - RF[8] unchanged if the edge was not reached.
  - move_count=0, state IDLE, busy=0.
- Preload move_count=0xFFFF via 65535 moves (or force), then one more move:
  - move_count=0x0000 after done.
- req0_valid pulsed high 1 cycle while busy:
  - No ready, no extra move.
  - move_count unchanged beyond the in-flight move.

Source files
------------

// File: rtl/mov_arbiter_ctrl.sv
// Round-robin arbiter sharing one register-to-register move path between two requesters.
// Accept -> READ -> WRITE -> done pulse (3 cycles/move); ready only offered in IDLE.
module mov_arbiter_ctrl #(
   parameter int N  = 32,
   parameter int A  = 5,
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req0_valid,
   input  logic [A-1:0]  req0_src,
   input  logic [A-1:0]  req0_dst,
   output logic          req0_ready,
   input  logic          req1_valid,
   input  logic [A-1:0]  req1_src,
   input  logic [A-1:0]  req1_dst,
   output logic          req1_ready,
   output logic [A-1:0]  rf_raddr,
   input  logic [N-1:0]  rf_rdata,
   output logic          rf_we,
   output logic [A-1:0]  rf_waddr,
   output logic [N-1:0]  rf_wdata,
   output logic [1:0]    done,
   output logic          busy,
   output logic [CW-1:0] move_count
);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE} state_t;

   state_t        r_state;
   logic          r_last;
   logic          r_owner;
   logic [A-1:0]  r_src;
   logic [A-1:0]  r_dst;
   logic [N-1:0]  r_data;
   logic [1:0]    r_done;
   logic [CW-1:0] r_count;

   logic          w_idle;
   logic          w_accept;
   logic          w_gnt;
   logic [A-1:0]  w_cmd_src;
   logic [A-1:0]  w_cmd_dst;

   // With both valid, the requester that did not win last time gets the grant.
   assign w_idle    = (r_state == S_IDLE);
   assign w_gnt     = (req0_valid && req1_valid) ? ~r_last : req1_valid;
   assign w_accept  = w_idle && (req0_valid || req1_valid);
   assign w_cmd_src = w_gnt ? req1_src : req0_src;
   assign w_cmd_dst = w_gnt ? req1_dst : req0_dst;

   assign req0_ready = w_accept && !w_gnt;
   assign req1_ready = w_accept && w_gnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_last  <= 1'b1;
         r_owner <= 1'b0;
         r_src   <= '0;
         r_dst   <= '0;
         r_data  <= '0;
         r_done  <= 2'b00;
         r_count <= '0;
      end else begin
         r_done <= 2'b00;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_src   <= w_cmd_src;
                  r_dst   <= w_cmd_dst;
                  r_owner <= w_gnt;
                  r_last  <= w_gnt;
                  r_state <= S_READ;
               end
            end
            S_READ: begin
               r_data  <= rf_rdata;
               r_state <= S_WRITE;
            end
            S_WRITE: begin
               r_done  <= r_owner ? 2'b10 : 2'b01;
               r_count <= r_count + CW'(1);
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Port outputs decode the registered state so reset drops them immediately.
   assign rf_raddr   = (r_state == S_READ)  ? r_src  : '0;
   assign rf_we      = (r_state == S_WRITE);
   assign rf_waddr   = (r_state == S_WRITE) ? r_dst  : '0;
   assign rf_wdata   = (r_state == S_WRITE) ? r_data : '0;
   assign done       = r_done;
   assign busy       = !w_idle;
   assign move_count = r_count;

endmodule

// File: tb/tb_mov_arbiter_ctrl.sv
// Bench for mov_arbiter_ctrl: directed scenarios plus randomized traffic against a
// transaction-level model (acceptance time t -> read t+1, write t+2, done t+3).
module tb_mov_arbiter_ctrl;
   localparam int N  = 32;
   localparam int A  = 5;
   localparam int CW = 10;

   logic          clk = 1'b0;
   logic          rst;
   logic          req0_valid, req1_valid;
   logic [A-1:0]  req0_src, req0_dst, req1_src, req1_dst;
   logic          req0_ready, req1_ready;
   logic [A-1:0]  rf_raddr, rf_waddr;
   logic [N-1:0]  rf_rdata, rf_wdata;
   logic          rf_we;
   logic [1:0]    done;
   logic          busy;
   logic [CW-1:0] move_count;

   logic [N-1:0]  rf [32];
   logic [N-1:0]  gold [32];
   logic          pre_we;
   logic [A-1:0]  pre_addr;
   logic [N-1:0]  pre_dat;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mov_arbiter_ctrl #(.N(N), .A(A), .CW(CW)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_src(req0_src), .req0_dst(req0_dst), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_src(req1_src), .req1_dst(req1_dst), .req1_ready(req1_ready),
      .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .rf_we(rf_we), .rf_waddr(rf_waddr),
      .rf_wdata(rf_wdata), .done(done), .busy(busy), .move_count(move_count)
   );

   // Register file with combinational read; the bench preloads it through pre_*.
   assign rf_rdata = rf[rf_raddr];
   always @(posedge clk) begin
      if (rf_we) rf[rf_waddr] <= rf_wdata;
      else if (pre_we) rf[pre_addr] <= pre_dat;
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic rf_load(input logic [A-1:0] a, input logic [N-1:0] d);
      pre_we = 1'b1; pre_addr = a; pre_dat = d;
      next_cycle();
      pre_we = 1'b0;
   endtask

   task automatic do_reset();
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_src = '0; req0_dst = '0; req1_src = '0; req1_dst = '0;
      rst = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b%b exp 00", req1_ready, req0_ready); end
      checks++; if (rf_we !== 1'b0 || rf_raddr !== '0 || rf_waddr !== '0 || rf_wdata !== '0) begin errors++; $display("FAIL reset_rf got we=%b ra=%0d wa=%0d wd=%h exp all 0", rf_we, rf_raddr, rf_waddr, rf_wdata); end
      checks++; if (done !== 2'b00) begin errors++; $display("FAIL reset_done got %b exp 00", done); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
      checks++; if (move_count !== '0) begin errors++; $display("FAIL reset_count got %0d exp 0", move_count); end
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_single_move();
      do_reset();
      rf_load(5'd3, 32'hDEADBEEF);
      rf_load(5'd7, 32'h0);
      req0_valid = 1'b1; req0_src = 5'd3; req0_dst = 5'd7;
      @(negedge clk);
      checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL single_ready got %b%b exp 01", req1_ready, req0_ready); end
      next_cycle();
      req0_valid = 1'b0;
      @(negedge clk);
      checks++; if (rf_raddr !== 5'd3 || busy !== 1'b1 || rf_we !== 1'b0) begin errors++; $display("FAIL single_read got ra=%0d busy=%b we=%b exp 3 1 0", rf_raddr, busy, rf_we); end
      next_cycle();
      @(negedge clk);
      checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'hDEADBEEF || rf_raddr !== '0) begin errors++; $display("FAIL single_write got we=%b wa=%0d wd=%h ra=%0d exp 1 7 deadbeef 0", rf_we, rf_waddr, rf_wdata, rf_raddr); end
      next_cycle();
      @(negedge clk);
      checks++; if (done !== 2'b01 || move_count !== CW'(1) || busy !== 1'b0) begin errors++; $display("FAIL single_done got done=%b cnt=%0d busy=%b exp 01 1 0", done, move_count, busy); end
      checks++; if (rf[7] !== 32'hDEADBEEF) begin errors++; $display("FAIL single_rf got %h exp deadbeef", rf[7]); end
      next_cycle();
      @(negedge clk);
      checks++; if (done !== 2'b00) begin errors++; $display("FAIL single_done_pulse got %b exp 00", done); end
   endtask

   task automatic test_fairness();
      logic       e_r0, e_r1;
      logic [1:0] e_done;
      do_reset();
      req0_valid = 1'b1; req0_src = 5'd1; req0_dst = 5'd2;
      req1_valid = 1'b1; req1_src = 5'd4; req1_dst = 5'd5;
      for (int t = 0; t <= 12; t++) begin
         if (t == 12) begin req0_valid = 1'b0; req1_valid = 1'b0; end
         @(negedge clk);
         e_r0   = (t % 3 == 0) && (t < 12) && ((t / 3) % 2 == 0);
         e_r1   = (t % 3 == 0) && (t < 12) && ((t / 3) % 2 == 1);
         e_done = (t >= 3 && t % 3 == 0) ? ((((t / 3) - 1) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
         checks++; if (req0_ready !== e_r0 || req1_ready !== e_r1) begin errors++; $display("FAIL fair_ready t=%0d got %b%b exp %b%b", t, req1_ready, req0_ready, e_r1, e_r0); end
         checks++; if (done !== e_done) begin errors++; $display("FAIL fair_done t=%0d got %b exp %b", t, done, e_done); end
         next_cycle();
      end
      @(negedge clk);
      checks++; if (move_count !== CW'(4)) begin errors++; $display("FAIL fair_count got %0d exp 4", move_count); end
   endtask

   task automatic test_same_reg();
      do_reset();
      rf_load(5'd9, 32'h12345678);
      req1_valid = 1'b1; req1_src = 5'd9; req1_dst = 5'd9;
      for (int t = 0; t <= 3; t++) begin
         if (t == 1) req1_valid = 1'b0;
         @(negedge clk);
         checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL same_r0 t=%0d got %b exp 0", t, req0_ready); end
         if (t == 0) begin
            checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL same_r1 got %b exp 1", req1_ready); end
         end
         if (t == 2) begin
            checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 32'h12345678) begin errors++; $display("FAIL same_write got we=%b wa=%0d wd=%h exp 1 9 12345678", rf_we, rf_waddr, rf_wdata); end
         end
         if (t == 3) begin
            checks++; if (done !== 2'b10 || move_count !== CW'(1)) begin errors++; $display("FAIL same_done got %b cnt=%0d exp 10 1", done, move_count); end
         end
         next_cycle();
      end
      checks++; if (rf[9] !== 32'h12345678) begin errors++; $display("FAIL same_rf got %h exp 12345678", rf[9]); end
   endtask

   task automatic test_reset_mid_write();
      do_reset();
      rf_load(5'd6, 32'hA5A5A5A5);
      rf_load(5'd8, 32'h11111111);
      req0_valid = 1'b1; req0_src = 5'd2; req0_dst = 5'd3;
      next_cycle();
      req0_valid = 1'b0;
      next_cycle();
      next_cycle();
      @(negedge clk);
      checks++; if (move_count !== CW'(1)) begin errors++; $display("FAIL rstmid_pre_count got %0d exp 1", move_count); end
      req0_valid = 1'b1; req0_src = 5'd6; req0_dst = 5'd8;
      next_cycle();
      req0_valid = 1'b0;
      next_cycle();
      @(negedge clk);
      checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd8) begin errors++; $display("FAIL rstmid_write got we=%b wa=%0d exp 1 8", rf_we, rf_waddr); end
      #1 rst = 1'b1;
      #1;
      checks++; if (rf_we !== 1'b0 || busy !== 1'b0 || done !== 2'b00 || move_count !== '0) begin errors++; $display("FAIL rstmid_async got we=%b busy=%b done=%b cnt=%0d exp 0 0 00 0", rf_we, busy, done, move_count); end
      @(posedge clk);
      @(negedge clk);
      checks++; if (rf_we !== 1'b0 || done !== 2'b00 || move_count !== '0) begin errors++; $display("FAIL rstmid_held got we=%b done=%b cnt=%0d exp 0 00 0", rf_we, done, move_count); end
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checks++; if (done !== 2'b00 || busy !== 1'b0 || move_count !== '0) begin errors++; $display("FAIL rstmid_after got done=%b busy=%b cnt=%0d exp 00 0 0", done, busy, move_count); end
      checks++; if (rf[8] !== 32'h11111111) begin errors++; $display("FAIL rstmid_rf got %h exp 11111111", rf[8]); end
   endtask

   task automatic test_pulse_while_busy();
      do_reset();
      req0_valid = 1'b1; req0_src = 5'd1; req0_dst = 5'd2;
      next_cycle();
      req0_valid = 1'b1; req0_src = 5'd5; req0_dst = 5'd6;
      for (int t = 1; t <= 7; t++) begin
         @(negedge clk);
         checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("FAIL pulse_ready t=%0d got %b%b exp 00", t, req1_ready, req0_ready); end
         checks++; if (done !== ((t == 3) ? 2'b01 : 2'b00)) begin errors++; $display("FAIL pulse_done t=%0d got %b", t, done); end
         if (t >= 3) begin
            checks++; if (rf_we !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL pulse_idle t=%0d got we=%b busy=%b exp 0 0", t, rf_we, busy); end
         end
         next_cycle();
         req0_valid = 1'b0;
      end
      checks++; if (move_count !== CW'(1)) begin errors++; $display("FAIL pulse_count got %0d exp 1", move_count); end
   endtask

   task automatic test_wrap();
      int moves = 1 << CW;
      do_reset();
      req0_valid = 1'b1; req0_src = 5'd10; req0_dst = 5'd11;
      for (int t = 0; t <= 3 * moves; t++) begin
         if (t == 3 * moves - 2) req0_valid = 1'b0;
         @(negedge clk);
         if (t == 3 * (moves - 1)) begin
            checks++; if (move_count !== CW'(moves - 1)) begin errors++; $display("FAIL wrap_max got %0d exp %0d", move_count, moves - 1); end
         end
         if (t == 3 * moves) begin
            checks++; if (move_count !== '0 || done !== 2'b01) begin errors++; $display("FAIL wrap_zero got cnt=%0d done=%b exp 0 01", move_count, done); end
         end
         next_cycle();
      end
   endtask

   task automatic test_random_traffic();
      logic          h_v [2];
      logic [A-1:0]  h_s [2];
      logic [A-1:0]  h_d [2];
      logic          taken [2];
      logic          p_vld, p_own, last, g, idle;
      int            p_acc;
      logic [A-1:0]  p_src, p_dst, e_raddr, e_waddr;
      logic [N-1:0]  p_dat, e_wdata;
      logic [CW-1:0] e_cnt;
      logic [1:0]    e_done, e_rdy;
      logic          e_we;
      int            bad;
      do_reset();
      for (int i = 0; i < 32; i++) gold[i] = rf[i];
      for (int i = 0; i < 2; i++) begin h_v[i] = 1'b0; h_s[i] = '0; h_d[i] = '0; taken[i] = 1'b0; end
      p_vld = 1'b0; p_own = 1'b0; p_acc = 0; p_src = '0; p_dst = '0; p_dat = '0;
      last = 1'b1; e_cnt = '0;
      for (int t = 0; t < 400; t++) begin
         for (int i = 0; i < 2; i++) begin
            if (taken[i]) h_v[i] = 1'b0;
            taken[i] = 1'b0;
            if (t >= 390) h_v[i] = 1'b0;
            else if (!h_v[i] && $urandom_range(0, 2) == 0) begin
               h_v[i] = 1'b1;
               h_s[i] = A'($urandom_range(0, 31));
               h_d[i] = A'($urandom_range(0, 31));
            end else if (h_v[i] && $urandom_range(0, 15) == 0) h_v[i] = 1'b0;
         end
         req0_valid = h_v[0]; req0_src = h_s[0]; req0_dst = h_d[0];
         req1_valid = h_v[1]; req1_src = h_s[1]; req1_dst = h_d[1];
         @(negedge clk);
         e_done = 2'b00;
         if (p_vld && t == p_acc + 3) begin
            e_done[p_own] = 1'b1;
            e_cnt = e_cnt + CW'(1);
            p_vld = 1'b0;
         end
         idle    = !p_vld;
         e_rdy   = 2'b00;
         g       = 1'b0;
         if (idle && (h_v[0] || h_v[1])) begin
            g = (h_v[0] && h_v[1]) ? !last : h_v[1];
            e_rdy[g] = 1'b1;
         end
         e_raddr = (p_vld && t == p_acc + 1) ? p_src : '0;
         e_we    = p_vld && (t == p_acc + 2);
         e_waddr = e_we ? p_dst : '0;
         e_wdata = e_we ? p_dat : '0;
         checks++; if ({req1_ready, req0_ready} !== e_rdy) begin errors++; $display("FAIL rand_ready t=%0d got %b%b exp %b", t, req1_ready, req0_ready, e_rdy); end
         checks++; if (rf_raddr !== e_raddr) begin errors++; $display("FAIL rand_raddr t=%0d got %0d exp %0d", t, rf_raddr, e_raddr); end
         checks++; if (rf_we !== e_we || rf_waddr !== e_waddr || rf_wdata !== e_wdata) begin errors++; $display("FAIL rand_write t=%0d got %b %0d %h exp %b %0d %h", t, rf_we, rf_waddr, rf_wdata, e_we, e_waddr, e_wdata); end
         checks++; if (done !== e_done || move_count !== e_cnt || busy !== !idle) begin errors++; $display("FAIL rand_status t=%0d got done=%b cnt=%0d busy=%b exp %b %0d %b", t, done, move_count, busy, e_done, e_cnt, !idle); end
         if (e_rdy != 2'b00) begin
            p_vld = 1'b1; p_acc = t; p_own = g;
            p_src = h_s[g]; p_dst = h_d[g]; p_dat = gold[h_s[g]];
            gold[h_d[g]] = p_dat;
            last = g;
            taken[g] = 1'b1;
         end
         next_cycle();
      end
      bad = 0;
      for (int i = 0; i < 32; i++) if (rf[i] !== gold[i]) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL rand_rf got %0d differing registers exp 0", bad); end
   endtask

   initial begin
      pre_we = 1'b0; pre_addr = '0; pre_dat = '0;
      rst = 1'b1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_src = '0; req0_dst = '0; req1_src = '0; req1_dst = '0;
      for (int i = 0; i < 32; i++) rf_load(A'(i), $urandom);
      test_reset();
      test_single_move();
      test_fairness();
      test_same_reg();
      test_reset_mid_write();
      test_pulse_while_busy();
      test_wrap();
      test_random_traffic();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
